// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for one shared add/sub datapath.
// A single operation is in flight at a time. Every output is registered.
module addsub_arbiter #(
    parameter int W   = 16,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic [1:0]   sub,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic [W:0]   result,
    output logic         busy,
    output logic [W-1:0] dp_a,
    output logic [W-1:0] dp_b,
    output logic         dp_sub,
    output logic         dp_start,
    input  logic [W:0]   dp_res
);

    localparam int CW = 4;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic               r_ptr;
    logic               r_owner;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_gnt;
    logic [1:0]         r_done;
    logic [W:0]         r_result;
    logic               r_busy;
    logic [W-1:0]       r_dp_a;
    logic [W-1:0]       r_dp_b;
    logic               r_dp_sub;
    logic               r_dp_start;

    logic [1:0][W-1:0] w_a;
    logic [1:0][W-1:0] w_b;
    logic               w_win;
    logic               w_accept;
    logic               w_finish;

    assign w_a = {a1, a0};
    assign w_b = {b1, b0};

    // Requester 1 wins when it is alone, or when both ask and the pointer favours it.
    assign w_win    = req[1] & (~req[0] | r_ptr);
    assign w_accept = (r_state == ST_IDLE) && (req != 2'b00);
    assign w_finish = (r_state == ST_RUN) && (r_cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 1'b0;
            r_owner    <= 1'b0;
            r_cnt      <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_result   <= '0;
            r_busy     <= 1'b0;
            r_dp_a     <= '0;
            r_dp_b     <= '0;
            r_dp_sub   <= 1'b0;
            r_dp_start <= 1'b0;
        end else begin
            r_gnt      <= '0;
            r_done     <= '0;
            r_dp_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_gnt      <= {w_win, ~w_win};
                        r_dp_start <= 1'b1;
                        r_dp_a     <= w_a[w_win];
                        r_dp_b     <= w_b[w_win];
                        r_dp_sub   <= sub[w_win];
                        r_owner    <= w_win;
                        r_ptr      <= ~w_win;
                        r_cnt      <= CW'(LAT);
                        r_busy     <= 1'b1;
                        r_state    <= ST_RUN;
                    end
                end
                default: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (w_finish) begin
                        r_result <= dp_res;
                        r_done   <= {r_owner, ~r_owner};
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign result   = r_result;
    assign busy     = r_busy;
    assign dp_a     = r_dp_a;
    assign dp_b     = r_dp_b;
    assign dp_sub   = r_dp_sub;
    assign dp_start = r_dp_start;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Randomized and directed bench for addsub_arbiter against a cycle-stamped
// transaction model; includes a delayed add/sub datapath model.
module tb_addsub_arbiter;
    localparam int W   = 16;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req;
    logic [W-1:0] a0, b0, a1, b1;
    logic [1:0]   sub;
    logic [1:0]   gnt, done;
    logic [W:0]   result;
    logic         busy;
    logic [W-1:0] dp_a, dp_b;
    logic         dp_sub, dp_start;
    logic [W:0]   dp_res;

    always #5 clk = ~clk;

    addsub_arbiter #(.W(W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sub(sub),
        .gnt(gnt), .done(done), .result(result), .busy(busy),
        .dp_a(dp_a), .dp_b(dp_b), .dp_sub(dp_sub), .dp_start(dp_start),
        .dp_res(dp_res)
    );

    // Datapath: result appears exactly LAT cycles after dp_start, junk otherwise.
    logic [W:0] pd [0:LAT-2];
    logic       pv [0:LAT-2];
    always @(posedge clk) begin
        pv[0] <= dp_start;
        pd[0] <= dp_sub ? ({1'b0, dp_a} - {1'b0, dp_b}) : ({1'b0, dp_a} + {1'b0, dp_b});
        for (int i = 1; i < LAT - 1; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end
    assign dp_res = (pv[LAT-2] === 1'b1) ? pd[LAT-2] : (W+1)'('h15A5A);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Transaction model: an accepted op finishes at a known cycle stamp.
    int         cyc = 0;
    bit         m_busy, m_ptr, m_owner;
    int         m_done_at;
    logic [W:0] m_val;
    logic [1:0] e_gnt, e_done;
    logic       e_start, e_busy, e_dpsub;
    logic [W:0] e_result;
    logic [W-1:0] e_dpa, e_dpb;

    task automatic model_edge();
        bit w;
        logic [W-1:0] oa, ob;
        cyc++;
        if (!rst_n) begin
            m_busy = 0; m_ptr = 0; m_owner = 0;
            e_gnt = 0; e_done = 0; e_start = 0; e_result = 0;
            e_dpa = 0; e_dpb = 0; e_dpsub = 0;
        end else begin
            e_gnt = 0; e_done = 0; e_start = 0;
            if (m_busy) begin
                if (cyc == m_done_at) begin
                    e_done   = m_owner ? 2'b10 : 2'b01;
                    e_result = m_val;
                    m_busy   = 0;
                end
            end else if (req != 2'b00) begin
                w  = (req == 2'b11) ? m_ptr : req[1];
                oa = w ? a1 : a0;
                ob = w ? b1 : b0;
                m_val = sub[w] ? ({1'b0, oa} - {1'b0, ob}) : ({1'b0, oa} + {1'b0, ob});
                e_gnt   = w ? 2'b10 : 2'b01;
                e_start = 1'b1;
                e_dpa   = oa;
                e_dpb   = ob;
                e_dpsub = sub[w];
                m_ptr     = !w;
                m_owner   = w;
                m_done_at = cyc + LAT;
                m_busy    = 1;
            end
        end
        e_busy = m_busy;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("gnt", gnt, e_gnt);
        chk("done", done, e_done);
        chk("dp_start", dp_start, e_start);
        chk("busy", busy, e_busy);
        chk("result", result, e_result);
        chk("dp_a", dp_a, e_dpa);
        chk("dp_b", dp_b, e_dpb);
        chk("dp_sub", dp_sub, e_dpsub);
    endtask

    task automatic drain();
        req = 2'b00;
        for (int i = 0; i < LAT + 2; i++) step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_rr;
        rst_n = 1'b0; req = 2'b11;
        a0 = 16'd1; b0 = 16'd2; a1 = 16'd40; b1 = 16'd10; sub = 2'b10;
        @(negedge clk);
        step(); step();
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_busy", busy, 1'b0);

        // Both held from reset: grants alternate starting at requester 0.
        rst_n = 1'b1;
        exp_rr = 2'b01;
        for (int i = 0; i < 13; i++) begin
            step();
            if (gnt != 2'b00) begin
                chk("rr_order", gnt, exp_rr);
                exp_rr = {exp_rr[0], exp_rr[1]};
            end
        end
        drain();

        req = 2'b01; a0 = 16'd3; b0 = 16'd3; sub = 2'b00;
        step();
        chk("add_gnt", gnt, 2'b01);
        drain();
        chk("add_res", result, 17'h00006);

        req = 2'b10; a1 = 16'd61560; b1 = 16'd60101; sub = 2'b00;
        step();
        drain();
        chk("carry_res", result, 17'h1DB3D);
        req = 2'b10; a1 = 16'd3; b1 = 16'd5; sub = 2'b10;
        step();
        drain();
        chk("borrow_res", result, 17'h1FFFE);

        // Abort in flight: reset one cycle after the grant.
        req = 2'b01; a0 = 16'd77; b0 = 16'd11; sub = 2'b00;
        step();
        step();
        rst_n = 1'b0; req = 2'b11;
        step();
        chk("abort_res", result, 17'h0);
        chk("abort_busy", busy, 1'b0);
        rst_n = 1'b1;
        step();
        chk("regrant", gnt, 2'b01);
        drain();

        // Operands move right after acceptance.
        req = 2'b01; a0 = 16'd100; b0 = 16'd7; sub = 2'b00;
        step();
        a0 = 16'd999; b0 = 16'd1; sub = 2'b01;
        drain();
        chk("sample_res", result, 17'd107);

        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            req   = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            a0    = 16'($urandom);
            b0    = 16'($urandom);
            a1    = 16'($urandom);
            b1    = 16'($urandom);
            sub   = 2'($urandom_range(0, 3));
            step();
        end
        rst_n = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter W, default 16, operand width of the shared add/sub datapath.
REQ-002 Parameter LAT, default 2, datapath latency in cycles from dp_start to dp_res valid; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 req  input  2  per-requester request; bit i belongs to requester i.
REQ-006 a0, b0  input  W each  requester 0 operands.
REQ-007 a1, b1  input  W each  requester 1 operands.
REQ-008 sub  input  2  per-requester op select: 0 = add, 1 = subtract.
REQ-009 gnt  output  2  one-cycle accept pulse to the granted requester.
REQ-010 done  output  2  one-cycle completion pulse to the owning requester.
REQ-011 result  output  W+1  last completed datapath result.
REQ-012 busy  output  1  high while an operation is in flight.
REQ-013 dp_a, dp_b  output  W each  operands driven to the shared datapath.
REQ-014 dp_sub  output  1  op select driven to the datapath.
REQ-015 dp_start  output  1  one-cycle issue strobe to the datapath.
REQ-016 dp_res  input  W+1  datapath result, valid LAT cycles after dp_start.

Function
REQ-017 FSM states SHALL be IDLE and RUN; every output SHALL be registered.
REQ-018 IDLE, req != 0 at an edge: winner chosen by round-robin pointer ptr; dp_a/dp_b/dp_sub loaded from winner's a/b/sub; gnt[winner], dp_start pulsed; cnt <= LAT; state -> RUN.
REQ-019 Arbitration: only one req bit set -> that requester wins; both set -> requester ptr wins.
REQ-020 After each grant ptr SHALL point to the non-granted requester; reset value of ptr is 0.
REQ-021 RUN: cnt decrements each edge; at the edge where cnt == 1: result <= dp_res, done[owner] pulsed, state -> IDLE.
REQ-022 Timing: request accepted at edge k -> gnt/dp_start high cycle k+1, done high cycle k+1+LAT.
REQ-023 IDLE SHALL accept a new request in the same cycle done is high; minimum issue period LAT+1 cycles.
REQ-024 Requests seen during RUN SHALL be ignored until IDLE; no queuing, no lost request while req is held.
REQ-025 Operands and sub are sampled only at the accept edge; later changes SHALL NOT affect the in-flight operation.
REQ-026 req dropped before grant: no grant, no state change.
REQ-027 dp_a/dp_b/dp_sub hold their values until the next accept.
REQ-028 result holds until the next completion; dp_res passes through unmodified (bit W is the carry/borrow).
REQ-029 busy = (state == RUN); gnt, done, dp_start are never high for more than one cycle and never both bits at once.

Reset
REQ-030 rst_n low at an edge: state IDLE, ptr 0, cnt 0, and gnt, done, dp_start, busy, result, dp_a, dp_b, dp_sub all 0.
REQ-031 Reset during RUN aborts the operation: no done pulse; the late dp_res is ignored.

Verification (bench datapath model: dp_res = dp_a +/- dp_b, delivered LAT cycles after dp_start; LAT = 2)
REQ-032 rst_n low 2 cycles, req = 2'b11 -> all outputs 0, no gnt during reset.
REQ-033 req = 2'b01, a0 = 3, b0 = 3, sub = 0 -> gnt = 01 at k+1, done = 01 at k+3, result = 17'h00006.
REQ-034 req = 2'b11 from reset, both held -> grants alternate 01, 10, 01, 10 every 3 cycles; each done matches its own operands.
REQ-035 req = 2'b10, a1 = 61560, b1 = 60101, sub = 0 -> result = 17'h1DB3D; then sub = 1 with a1 = 3, b1 = 5 -> result = 17'h1FFFE.
REQ-036 rst_n low one cycle after gnt -> no done, result = 0, busy = 0; a held req is regranted after reset with ptr = 0.
REQ-037 Operands changed one cycle after gnt -> result reflects the operands sampled at the accept edge.
